// File: rtl/s420_state_gen_if.sv
// Serial coefficient stream between a coefficient source and s420_state_gen.
// The master drives data, valid and last; the slave returns ready.
interface s420_state_gen_if;
   logic CS_D;
   logic CS_VALID;
   logic CS_READY;
   logic CS_LAST;

   modport master (output CS_D, output CS_VALID, output CS_LAST, input CS_READY);
   modport slave  (input CS_D, input CS_VALID, input CS_LAST, output CS_READY);
endinterface

// File: rtl/s420_state_gen.sv
// State and coefficient front stage for the s420 Z cone: an X-driven up-counter
// gated by a committed coefficient that is loaded serially, LSB first.
module s420_state_gen #(
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned COEF_W  = 17,
   parameter bit          WRAP_EN = 1'b1
) (
   input  logic              CK,
   input  logic              RN,
   input  logic              X,
   input  logic              CLR,
   s420_state_gen_if.slave   cs,
   output logic [CNT_W-1:0]  Y,
   output logic [COEF_W-1:0] C,
   output logic              COEF_OK,
   output logic              WRAP,
   output logic              FRAME_ERR
);

   // bitcnt must reach COEF_W+1 so that over-long frames stay distinguishable
   localparam int unsigned BC_W  = $clog2(COEF_W + 2);
   localparam int unsigned IDX_W = $clog2(COEF_W);
   localparam logic [BC_W-1:0]  BC_FULL = BC_W'(COEF_W);
   localparam logic [BC_W-1:0]  BC_OVER = BC_W'(COEF_W + 1);
   localparam logic [CNT_W-1:0] Y_MAX   = '1;
   localparam logic [CNT_W-1:0] Y_PEN   = Y_MAX - CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t            state;
   logic [COEF_W-1:0] shadow;
   logic [BC_W-1:0]   bitcnt;
   logic              cs_ready_q;
   logic              accept_c;

   assign cs.CS_READY = cs_ready_q;
   assign accept_c    = cs.CS_VALID & cs_ready_q;

   // Coefficient loader: shadow fills bit by bit, C only moves on a clean commit
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state      <= IDLE;
         shadow     <= '0;
         bitcnt     <= '0;
         C          <= '0;
         COEF_OK    <= 1'b0;
         FRAME_ERR  <= 1'b0;
         cs_ready_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               cs_ready_q <= 1'b1;
               if (accept_c) begin
                  shadow[0] <= cs.CS_D;
                  bitcnt    <= BC_W'(1);
                  if (cs.CS_LAST) begin
                     state      <= COMMIT;
                     cs_ready_q <= 1'b0;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               cs_ready_q <= 1'b1;
               if (accept_c) begin
                  if (bitcnt < BC_FULL) shadow[bitcnt[IDX_W-1:0]] <= cs.CS_D;
                  if (bitcnt < BC_OVER) bitcnt <= bitcnt + BC_W'(1);
                  if (cs.CS_LAST) begin
                     state      <= COMMIT;
                     cs_ready_q <= 1'b0;
                  end
               end
            end
            COMMIT: begin
               if (bitcnt == BC_FULL) begin
                  C       <= shadow;
                  COEF_OK <= 1'b1;
               end else begin
                  FRAME_ERR <= 1'b1;
               end
               bitcnt     <= '0;
               state      <= IDLE;
               cs_ready_q <= 1'b1;
            end
            default: begin
               state      <= IDLE;
               cs_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // State counter; uses the pre-edge COEF_OK so a first commit enables counting next cycle
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         Y    <= '0;
         WRAP <= 1'b0;
      end else begin
         WRAP <= 1'b0;
         if (CLR) begin
            Y <= '0;
         end else if (COEF_OK && X) begin
            if (Y != Y_MAX) begin
               Y <= Y + CNT_W'(1);
               if (!WRAP_EN && (Y == Y_PEN)) WRAP <= 1'b1;
            end else if (WRAP_EN) begin
               Y    <= '0;
               WRAP <= 1'b1;
            end
         end
      end
   end

endmodule
